posit_divider_8bit_seq: RTL

Iterative divider for 8-bit posits (es = 0) that computes `dividend / divisor` and returns a rounded 8-bit posit. It is the inverse companion of the combinational 8-bit posit multiplier and shares the same posit format. It sits on the arithmetic datapath behind a valid/ready handshake. One restoring-division quotient bit is produced per cycle, trading latency for area.

---
 rtl/posit_divider_8bit_seq_if.sv | 21 ++
 rtl/posit_divider_8bit_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/posit_divider_8bit_seq_if.sv
// Handshake bundle for the sequential 8-bit posit divider: operand request side and result side.
interface posit_divider_8bit_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic       busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, busy
    );
endinterface

// File: rtl/posit_divider_8bit_seq.sv
// Iterative posit<8,0> divider: decode, 8-cycle restoring mantissa division, regime/fraction
// rounding (nearest, ties to even), and a registered result held until consumed.
module posit_divider_8bit_seq (
    input  logic                           clk,
    input  logic                           rst_n,
    posit_divider_8bit_seq_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        DIV    = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic signed [5:0] scale_q, scale_d;
    logic [6:0]        rem_q, rem_d;
    logic [5:0]        dvs_q, dvs_d;
    logic [7:0]        quo_q, quo_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        quotient_q, quotient_d;

    logic [6:0]        mag_a, mag_b;
    logic [10:0]       dec_a, dec_b;
    logic signed [4:0] k_a, k_b;
    logic [5:0]        mant_a, mant_b;
    logic              is_nar, is_zero;
    logic              res_sign;
    logic              ge;
    logic [5:0]        diff;
    logic [6:0]        frac_n;
    logic signed [5:0] scale_n;
    logic [6:0]        body;
    logic              in_ready, out_valid, busy;

    // Returns {k[4:0], mantissa 1.fffff} for a nonzero positive posit body.
    function automatic logic [10:0] posit_decode(input logic [6:0] pbody);
        logic              r;
        int                run;
        logic              stop;
        logic signed [4:0] k;
        logic [4:0]        frac;
        r    = pbody[6];
        run  = 0;
        stop = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!stop && (pbody[i] == r)) run++;
            else stop = 1'b1;
        end
        k    = r ? 5'(run - 1) : 5'(-run);
        frac = 5'(({pbody, 5'b0} << (run + 1)) >> 7);
        return {k, 1'b1, frac};
    endfunction

    // Packs regime then fraction into a 16-bit window; bit 8 is guard, below it is sticky.
    function automatic logic [6:0] posit_encode(input logic signed [5:0] scale,
                                                input logic [6:0]        frac,
                                                input logic              sticky);
        int          ki;
        int          rlen;
        logic [15:0] regv;
        logic [15:0] w;
        logic [6:0]  pbody;
        logic        guard;
        logic        st;
        ki    = int'(scale);
        rlen  = 0;
        regv  = 16'h0000;
        w     = 16'h0000;
        guard = 1'b0;
        st    = 1'b0;
        if (ki > 6) begin
            pbody = 7'h7F;
        end else if (ki < -6) begin
            pbody = 7'h01;
        end else begin
            if (ki >= 0) begin
                rlen = ki + 2;
                regv = (16'hFFFF >> (15 - ki)) << 1;
            end else begin
                rlen = 1 - ki;
                regv = 16'h0001;
            end
            w     = (regv << (16 - rlen)) | ({frac, 9'b0} >> rlen);
            pbody = w[15:9];
            guard = w[8];
            st    = (|w[7:0]) | sticky;
            if (guard && (st || pbody[0])) pbody = pbody + 7'd1;
        end
        return pbody;
    endfunction

    always_comb begin
        mag_a    = a_q[7] ? 7'(-a_q) : a_q[6:0];
        mag_b    = b_q[7] ? 7'(-b_q) : b_q[6:0];
        dec_a    = posit_decode(mag_a);
        dec_b    = posit_decode(mag_b);
        k_a      = dec_a[10:6];
        k_b      = dec_b[10:6];
        mant_a   = dec_a[5:0];
        mant_b   = dec_b[5:0];
        is_nar   = (a_q == 8'h80) || (b_q == 8'h80) || (b_q == 8'h00);
        is_zero  = (a_q == 8'h00);
        res_sign = a_q[7] ^ b_q[7];

        ge       = (rem_q >= {1'b0, dvs_q});
        diff     = ge ? 6'(rem_q - {1'b0, dvs_q}) : rem_q[5:0];

        // The quotient lies in (0.5, 2), so at most one left shift normalises it.
        frac_n   = quo_q[7] ? quo_q[6:0] : {quo_q[5:0], 1'b0};
        scale_n  = quo_q[7] ? scale_q : scale_q - 6'sd1;
        body     = posit_encode(scale_n, frac_n, |rem_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = DECODE;
            DECODE:  state_d = (is_nar || is_zero) ? DONE : DIV;
            DIV:     if (cnt_q == 3'd0) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        scale_d    = scale_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.dividend;
                    b_d = bus.divisor;
                end
            end
            DECODE: begin
                if (is_nar) begin
                    quotient_d = 8'h80;
                end else if (is_zero) begin
                    quotient_d = 8'h00;
                end else begin
                    rem_d   = {1'b0, mant_a};
                    dvs_d   = mant_b;
                    scale_d = {k_a[4], k_a} - {k_b[4], k_b};
                    quo_d   = 8'h00;
                    cnt_d   = 3'd7;
                end
            end
            DIV: begin
                rem_d = {diff, 1'b0};
                quo_d = {quo_q[6:0], ge};
                if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            end
            ROUND: begin
                quotient_d = res_sign ? 8'(-{1'b0, body}) : {1'b0, body};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            scale_q    <= 6'sd0;
            rem_q      <= 7'h00;
            dvs_q      <= 6'h00;
            quo_q      <= 8'h00;
            cnt_q      <= 3'd0;
            quotient_q <= 8'h00;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            scale_q    <= scale_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.quotient  = quotient_q;

endmodule
